// File: rtl/addsub_accumulator.sv
// -----------------------------------------------------------------------------
// addsub_accumulator
//   Single-command accumulator with LOAD / ADD / SUB / CLEAR operations.
//   A command is accepted in IDLE, executed in EXEC through a mode-controlled
//   two's-complement adder/subtractor, and presented in DONE until the consumer
//   takes it. Only one command is in flight at a time.
//
//   Optional feature macro: ADDSUB_ACC_SAT_EN
//     When defined, an ADD/SUB result that overflows in signed terms is clamped
//     to the most positive or most negative value. ovf still reads 1 and carry
//     still reads the raw adder carry. When undefined, results wrap.
//
// Parameters
//   WIDTH      datapath width (>= 2)
//   CNT_WIDTH  width of the completed ADD/SUB counter
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   command present
//   in_ready   command can be accepted (IDLE only)
//   op         00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   operand    command operand
//   out_valid  result and flags valid (DONE)
//   out_ready  consumer accepts result
//   acc        accumulator value
//   carry      adder carry-out (for SUB: 1 = no borrow)
//   ovf        signed overflow of the last ADD/SUB
//   zero       acc == 0
//   neg        acc sign bit
//   op_count   completed ADD/SUB count, saturating
// -----------------------------------------------------------------------------
module addsub_accumulator #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     acc,
    output logic                 carry,
    output logic                 ovf,
    output logic                 zero,
    output logic                 neg,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] EXEC = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0]     ACC_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]     SAT_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]     SAT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Mode-controlled adder/subtractor: mode=1 inverts b and injects a carry-in,
    // so the returned MSB is the carry-out (1 = no borrow for subtraction).
    function automatic logic [WIDTH:0] addsub(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             mode);
        logic [WIDTH-1:0] b_eff;
        b_eff  = b ^ {WIDTH{mode}};
        addsub = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, mode};
    endfunction

    // Signed overflow: the effective addend (b inverted for SUB) has the same
    // sign as a, but the result sign differs from a.
    function automatic logic signed_ovf(input logic a_sign,
                                        input logic b_sign,
                                        input logic r_sign,
                                        input logic mode);
        signed_ovf = (a_sign == (b_sign ^ mode)) && (r_sign != a_sign);
    endfunction

    logic [1:0]           state_r;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     operand_r;
    logic [WIDTH-1:0]     acc_r;
    logic                 carry_r;
    logic                 ovf_r;
    logic                 out_valid_r;
    logic [CNT_WIDTH-1:0] op_count_r;

    logic                 mode_s;
    logic [WIDTH:0]       sum_s;
    logic                 arith_ovf_s;
    logic [WIDTH-1:0]     arith_res_s;
    logic [WIDTH-1:0]     next_acc_s;
    logic                 next_carry_s;
    logic                 next_ovf_s;
    logic [CNT_WIDTH-1:0] next_cnt_s;

    // Adder/subtractor result and overflow handling for the captured command.
    always_comb begin
        mode_s      = (op_r == OP_SUB);
        sum_s       = addsub(acc_r, operand_r, mode_s);
        arith_ovf_s = signed_ovf(acc_r[WIDTH-1], operand_r[WIDTH-1], sum_s[WIDTH-1], mode_s);
`ifdef ADDSUB_ACC_SAT_EN
        // On overflow the true result has the sign of acc, so acc's sign picks the rail.
        if (arith_ovf_s) begin
            arith_res_s = acc_r[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end else begin
            arith_res_s = sum_s[WIDTH-1:0];
        end
`else
        arith_res_s = sum_s[WIDTH-1:0];
`endif
    end

    // Next accumulator, flags and counter for the command in EXEC.
    always_comb begin
        next_acc_s   = acc_r;
        next_carry_s = carry_r;
        next_ovf_s   = ovf_r;
        next_cnt_s   = op_count_r;
        case (op_r)
            OP_LOAD: begin
                next_acc_s   = operand_r;
                next_carry_s = 1'b0;
                next_ovf_s   = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                next_acc_s   = arith_res_s;
                next_carry_s = sum_s[WIDTH];
                next_ovf_s   = arith_ovf_s;
                if (op_count_r != CNT_MAX) begin
                    next_cnt_s = op_count_r + CNT_ONE;
                end else begin
                    next_cnt_s = op_count_r;
                end
            end
            OP_CLEAR: begin
                next_acc_s   = ACC_ZERO;
                next_carry_s = 1'b0;
                next_ovf_s   = 1'b0;
                next_cnt_s   = CNT_ZERO;
            end
            default: begin
                next_acc_s   = acc_r;
                next_carry_s = carry_r;
                next_ovf_s   = ovf_r;
                next_cnt_s   = op_count_r;
            end
        endcase
    end

    // Control FSM, command capture and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            op_r        <= OP_LOAD;
            operand_r   <= ACC_ZERO;
            acc_r       <= ACC_ZERO;
            carry_r     <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
            op_count_r  <= CNT_ZERO;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r      <= op;
                        operand_r <= operand;
                        state_r   <= EXEC;
                    end
                end
                EXEC: begin
                    acc_r       <= next_acc_s;
                    carry_r     <= next_carry_s;
                    ovf_r       <= next_ovf_s;
                    op_count_r  <= next_cnt_s;
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // in_ready is gated by rst_n so it reads 0 throughout reset.
    assign in_ready  = rst_n & (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign acc       = acc_r;
    assign carry     = carry_r;
    assign ovf       = ovf_r;
    assign op_count  = op_count_r;
    assign zero      = (acc_r == ACC_ZERO);
    assign neg       = acc_r[WIDTH-1];

endmodule

// File: tb/tb_addsub_accumulator.sv
// -----------------------------------------------------------------------------
// tb_addsub_accumulator
//   Self-checking bench for addsub_accumulator (WIDTH=8, CNT_WIDTH=2 so counter
//   saturation is reached quickly). Expected values come from an integer-
//   arithmetic reference model. Honours ADDSUB_ACC_SAT_EN like the design.
// -----------------------------------------------------------------------------
module tb_addsub_accumulator;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  operand;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  acc;
    logic          carry;
    logic          ovf;
    logic          zero;
    logic          neg;
    logic [CW-1:0] op_count;

    int n_cmp;
    int n_bad;

    // reference model state
    logic [W-1:0]  m_acc;
    logic          m_carry;
    logic          m_ovf;
    int            m_cnt;

    addsub_accumulator #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc   = 8'h00;
        m_carry = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = 0;
    endtask

    // Behavioural effect of one command, in plain integer arithmetic.
    task automatic model_cmd(input logic [1:0] c_op, input logic [W-1:0] v);
        int ua;
        int sa;
        logic [W-1:0] r;
        case (c_op)
            2'b00: begin m_acc = v; m_carry = 1'b0; m_ovf = 1'b0; end
            2'b11: begin m_acc = 8'h00; m_carry = 1'b0; m_ovf = 1'b0; m_cnt = 0; end
            default: begin
                if (c_op == 2'b01) begin
                    ua = int'(m_acc) + int'(v);
                    sa = int'($signed(m_acc)) + int'($signed(v));
                    m_carry = (ua > 255);
                end else begin
                    ua = int'(m_acc) - int'(v);
                    sa = int'($signed(m_acc)) - int'($signed(v));
                    m_carry = (int'(m_acc) >= int'(v));
                end
                m_ovf = (sa > 127) || (sa < -128);
                r = ua[7:0];
`ifdef ADDSUB_ACC_SAT_EN
                if (m_ovf) r = (sa > 127) ? 8'h7F : 8'h80;
`endif
                m_acc = r;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        endcase
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_acc"},   acc,      m_acc);
        chk({tag, "_carry"}, carry,    m_carry);
        chk({tag, "_ovf"},   ovf,      m_ovf);
        chk({tag, "_zero"},  zero,     (m_acc == 8'h00));
        chk({tag, "_neg"},   neg,      m_acc[7]);
        chk({tag, "_cnt"},   op_count, m_cnt);
    endtask

    // Issue one command, hold out_ready low for 'hold' DONE cycles while
    // offering junk commands, then hand the result off.
    task automatic run_cmd(input string tag, input logic [1:0] c_op,
                           input logic [W-1:0] c_v, input int hold);
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
        in_valid  = 1'b1;
        op        = c_op;
        operand   = c_v;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // accepted; keep in_valid high with different values that must be ignored
        op      = 2'($urandom_range(0, 3));
        operand = 8'($urandom);
        chk({tag, "_exec_out_valid"}, out_valid, 1'b0);
        chk({tag, "_exec_in_ready"},  in_ready,  1'b0);
        model_cmd(c_op, c_v);
        @(posedge clk); #1;
        chk({tag, "_done_out_valid"}, out_valid, 1'b1);
        chk_outputs(tag);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            op      = 2'($urandom_range(0, 3));
            operand = 8'($urandom);
            @(posedge clk); #1;
            chk({tag, "_hold_out_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_in_ready"},  in_ready,  1'b0);
            chk({tag, "_hold_acc"},       acc,       m_acc);
            chk({tag, "_hold_flags"},     {carry, ovf}, {m_carry, m_ovf});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ack_out_valid"}, out_valid, 1'b0);
        chk({tag, "_ack_in_ready"},  in_ready,  1'b1);
        chk({tag, "_ack_acc"},       acc,       m_acc);
    endtask

    initial begin
        logic [1:0] r_op;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        op = 2'b00;
        operand = 8'h00;
        out_ready = 1'b0;
        model_reset();

        // reset state
        #12;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1'b1);

        // LOAD 5, ADD 3 -> 8
        run_cmd("load05", 2'b00, 8'h05, 0);
        run_cmd("add03", 2'b01, 8'h03, 0);
        chk("add03_lit_acc", acc, 8'h08);
        chk("add03_lit_cnt", op_count, 2'd1);

        // LOAD 7F, ADD 1 -> signed overflow
        run_cmd("load7f", 2'b00, 8'h7F, 0);
        run_cmd("add01", 2'b01, 8'h01, 0);
`ifdef ADDSUB_ACC_SAT_EN
        chk("ovf_lit_acc", acc, 8'h7F);
`else
        chk("ovf_lit_acc", acc, 8'h80);
        chk("ovf_lit_neg", neg, 1'b1);
`endif
        chk("ovf_lit_ovf", ovf, 1'b1);

        // LOAD 3, SUB 3 -> 0 with no borrow; SUB 1 -> FF with borrow
        run_cmd("load03", 2'b00, 8'h03, 0);
        run_cmd("sub03", 2'b10, 8'h03, 0);
        chk("sub03_lit", {acc, carry, zero}, {8'h00, 1'b1, 1'b1});
        run_cmd("sub01", 2'b10, 8'h01, 0);
        chk("sub01_lit", {acc, carry, neg}, {8'hFF, 1'b0, 1'b1});

        // consumer stall for 5 cycles in DONE
        run_cmd("stall", 2'b01, 8'h22, 5);

        // reset in EXEC of ADD 0x10
        run_cmd("preld", 2'b00, 8'h33, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op = 2'b01;
        operand = 8'h10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", in_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rel_out_valid", out_valid, 1'b0);
        chk_outputs("post_rel");

        // counter saturation then CLEAR
        for (int i = 0; i < 5; i++) run_cmd("sat_add", 2'b01, 8'h01, 0);
        chk("sat_cnt_lit", op_count, 2'd3);
        run_cmd("clear", 2'b11, 8'h5A, 0);
        chk("clear_lit", {acc, op_count}, {8'h00, 2'd0});

        // randomized commands against the model
        for (int i = 0; i < 60; i++) begin
            r_op = 2'($urandom_range(0, 9) < 2 ? 0 :
                      ($urandom_range(0, 9) < 1 ? 3 : $urandom_range(1, 2)));
            run_cmd("rnd", r_op, 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
ADDSUB_ACCUMULATOR -- requirements
Module: addsub_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width (>=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of the operation counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  command present.
REQ-006 SHALL have port in_ready  output  1  block can accept a command.
REQ-007 SHALL have port op  input  2  command: 00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
REQ-008 SHALL have port operand  input  WIDTH  command operand.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port acc  output  WIDTH  accumulator value.
REQ-012 SHALL have port carry  output  1  adder carry-out; for SUB, 1 means no borrow.
REQ-013 SHALL have port ovf  output  1  signed overflow of the last ADD/SUB.
REQ-014 SHALL have port zero  output  1  acc equals 0.
REQ-015 SHALL have port neg  output  1  acc[WIDTH-1].
REQ-016 SHALL have port op_count  output  CNT_WIDTH  completed ADD/SUB count, saturating at all-ones.

Function
REQ-017 SHALL implement FSM states IDLE, EXEC, DONE.
REQ-018 SHALL assert in_ready only in IDLE; a command is accepted on a rising edge with in_valid && in_ready, capturing op and operand, and moving to EXEC.
REQ-019 SHALL, in EXEC, compute acc +/- operand through the codebase's mode-controlled two's-complement adder/subtractor (mode = 1 for SUB), register acc/carry/ovf, and move to DONE on the next edge.
REQ-020 SHALL drive out_valid high exactly while in DONE; accepted command to out_valid high is 2 cycles.
REQ-021 SHALL hold acc and all flags stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL allow no command acceptance while in EXEC or DONE (no pipelining, one command in flight).
REQ-023 SHALL, for LOAD, set acc = operand, carry = 0, ovf = 0.
REQ-024 SHALL, for CLEAR, set acc = 0, carry = 0, ovf = 0, and op_count = 0.
REQ-025 SHALL compute ovf as: ADD, operand signs equal and result sign differs from them; SUB, signs of acc and operand differ and result sign differs from acc sign.
REQ-026 SHALL wrap acc modulo 2^WIDTH on ADD/SUB (default build).
REQ-027 SHALL derive zero and neg combinationally from the registered acc.
REQ-028 SHALL increment op_count on each completed ADD/SUB, holding at 2^CNT_WIDTH-1.
REQ-029 SHALL ignore op/operand changes while not in IDLE.

Reset
REQ-030 SHALL, on rst_n low at any time, including mid-EXEC or DONE, immediately force state IDLE, acc 0, carry 0, ovf 0, op_count 0, out_valid 0; in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-031 SHALL discard any in-flight command on reset, with no partial update after release.

Configuration
REQ-032 SHALL, with macro ADDSUB_ACC_SAT_EN defined, clamp ADD/SUB results on signed overflow to +2^(WIDTH-1)-1 (positive overflow) or -2^(WIDTH-1) (negative overflow), with ovf still 1 and carry still the raw adder carry.
REQ-033 SHALL, without ADDSUB_ACC_SAT_EN, wrap per REQ-026; all other behaviour identical.

Verification (WIDTH=8)
REQ-034 SHALL cover: LOAD 0x05, then ADD 0x03 -> acc 0x08, carry 0, ovf 0, zero 0, out_valid 2 cycles after acceptance, op_count 1.
REQ-035 SHALL cover: LOAD 0x7F, ADD 0x01 -> default acc 0x80, ovf 1, neg 1; with ADDSUB_ACC_SAT_EN acc 0x7F, ovf 1.
REQ-036 SHALL cover: LOAD 0x03, SUB 0x03 -> acc 0x00, carry 1, zero 1; then SUB 0x01 -> acc 0xFF, carry 0, neg 1.
REQ-037 SHALL cover: out_ready held low 5 cycles in DONE -> acc/flags stable, in_ready 0, in_valid with new commands ignored; release -> IDLE next edge.
REQ-038 SHALL cover: rst_n pulsed low during EXEC of ADD 0x10 -> acc 0, out_valid 0, op_count 0, no update after release.
REQ-039 SHALL cover: CNT_WIDTH=2, 5 ADDs -> op_count 3; CLEAR -> op_count 0, acc 0.
